// File: rtl/div_if.sv
// div_if: handshake and operand/result bundle for the sequential divider.
//   master: start, dividend, divisor out; busy, done, quotient, remainder, div_by_zero in
//   slave : mirror of master (implemented by div)
interface div_if #(
   parameter int unsigned BUS_WIDTH = 16
);
   logic                 start;
   logic [BUS_WIDTH-1:0] dividend;
   logic [BUS_WIDTH-1:0] divisor;
   logic                 busy;
   logic                 done;
   logic [BUS_WIDTH-1:0] quotient;
   logic [BUS_WIDTH-1:0] remainder;
   logic                 div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div.sv
// div: sequential unsigned restoring divider, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : div_if.slave -- start/dividend/divisor in; busy, done (1-cycle pulse),
//          quotient, remainder, div_by_zero out (all registered)
module div #(
   parameter int unsigned BUS_WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);
   localparam int unsigned W     = BUS_WIDTH;
   localparam int unsigned CNT_W = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     dvsr;

   logic [W:0]       r_sh;
   logic [W+1:0]     diff;
   logic             no_borrow;
   logic             accept;

   // Trial subtraction. The shifted remainder keeps its carry-out bit so that
   // divisors with the MSB set still produce correct results.
   always_comb begin
      r_sh      = {bus.remainder, bus.quotient[W-1]};
      diff      = {1'b0, r_sh} - {2'b00, dvsr};
      no_borrow = ~diff[W+1];
      accept    = bus.start && (state != RUN);
   end

   // Control and datapath; quotient/remainder double as the working {R, Q} pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         dvsr            <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            if (bus.divisor == '0) begin
               state           <= DONE;
               bus.quotient    <= '1;
               bus.remainder   <= bus.dividend;
               bus.div_by_zero <= 1'b1;
               bus.busy        <= 1'b0;
               bus.done        <= 1'b1;
            end else begin
               state           <= RUN;
               bus.quotient    <= bus.dividend;
               bus.remainder   <= '0;
               bus.div_by_zero <= 1'b0;
               dvsr            <= bus.divisor;
               cnt             <= '0;
               bus.busy        <= 1'b1;
            end
         end else begin
            case (state)
               RUN: begin
                  bus.remainder <= no_borrow ? diff[W-1:0] : r_sh[W-1:0];
                  bus.quotient  <= {bus.quotient[W-2:0], no_borrow};
                  cnt           <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(W-1)) begin
                     state    <= DONE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div; reference results come from plain / and %.
module tb_div;
   localparam int unsigned W = 16;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           cyc;
      int           busy_len;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   logic [W-1:0] last_q, last_r;
   logic         last_dbz;
   int           run_len;

   div_if #(.BUS_WIDTH(W)) bus ();

   div #(.BUS_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per done pulse; checks hold values while idle.
   always @(negedge clk) begin
      if (rst) begin
         run_len  = 0;
         last_q   = '0;
         last_r   = '0;
         last_dbz = 1'b0;
      end else begin
         check_v("busy_done_exclusive", W'(bus.busy & bus.done), '0);
         if (bus.done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_v("quotient", bus.quotient, e.q);
               check_v("remainder", bus.remainder, e.r);
               check_v("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
               check_i("done_cycle", cyc, e.cyc);
               check_i("busy_cycles", run_len, e.busy_len);
               last_q   = e.q;
               last_r   = e.r;
               last_dbz = e.dbz;
            end
            run_len = 0;
         end else if (bus.busy) begin
            run_len++;
         end else begin
            run_len = 0;
            check_v("hold_quotient", bus.quotient, last_q);
            check_v("hold_remainder", bus.remainder, last_r);
            check_v("hold_div_by_zero", W'(bus.div_by_zero), W'(last_dbz));
         end
      end
   end

   // Drives one start at the current negedge; returns at the following negedge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit accepted);
      exp_t e;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (accepted) begin
         e.q        = (b == '0) ? '1 : a / b;
         e.r        = (b == '0) ? a : a % b;
         e.dbz      = (b == '0);
         e.cyc      = cyc + 1 + ((b == '0) ? 0 : int'(W));
         e.busy_len = (b == '0) ? 0 : int'(W);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
   endtask

   // Stops at the negedge where done is visible, or fails after a bounded wait.
   task automatic wait_done();
      for (int i = 0; i < 3 * int'(W) + 8; i++) begin
         if (bus.done) return;
         @(negedge clk);
      end
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 3 * W + 8);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_v({tag, "_busy"}, W'(bus.busy), '0);
      check_v({tag, "_done"}, W'(bus.done), '0);
      check_v({tag, "_quotient"}, bus.quotient, '0);
      check_v({tag, "_remainder"}, bus.remainder, '0);
      check_v({tag, "_div_by_zero"}, W'(bus.div_by_zero), '0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed operands, each followed by an idle cycle
      issue(16'd100, 16'd7, 1'b1);    wait_done(); @(negedge clk);
      issue(16'hFFFF, 16'd1, 1'b1);   wait_done(); @(negedge clk);
      issue(16'd3, 16'd10, 1'b1);     wait_done(); @(negedge clk);
      issue(16'hFFFF, 16'hFFFF, 1'b1); wait_done(); @(negedge clk);
      issue(16'd5, 16'd0, 1'b1);      wait_done(); @(negedge clk);
      issue(16'd8, 16'd2, 1'b1);      wait_done(); @(negedge clk);

      // Start during RUN is ignored; no second done may follow
      issue(16'd100, 16'd7, 1'b1);
      repeat (3) @(negedge clk);
      issue(16'd9, 16'd3, 1'b0);
      wait_done();
      repeat (W + 4) @(negedge clk);

      // Back-to-back: second start in the DONE cycle of the first
      issue(16'd100, 16'd7, 1'b1);
      wait_done();
      issue(16'd200, 16'd9, 1'b1);
      wait_done(); @(negedge clk);

      // Async reset mid-RUN: outputs clear without a clock edge, no done
      issue(16'd100, 16'd7, 1'b1);
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (W + 4) @(negedge clk);
      issue(16'd50, 16'd5, 1'b1);     wait_done(); @(negedge clk);

      // Randomized operations with random back-to-back or idle gaps
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = a;
            3:       b = W'($urandom) | 16'h8000;
            default: b = W'($urandom);
         endcase
         issue(a, b, 1'b1);
         wait_done();
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
      @(negedge clk);

      repeat (W + 4) @(negedge clk);
      check_i("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
